// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks.
package sc_pkg;

    // nummax scaling factor width used across the stochastic chain
    localparam int unsigned NUM_W = 9;

    // Decoder control states
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CALC,
        DONE
    } sc_dec_state_t;

endpackage

// File: rtl/sc_window_counter.sv
// Observation-window counter: counts ones in the stream and tracks the
// sample index so the owner knows when the N-th sample is being taken.
module sc_window_counter #(
    parameter int unsigned LOG2_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                bit_in,
    output logic [LOG2_LEN:0]   ones,
    output logic                last_sample
);

    logic [LOG2_LEN:0]   ones_q, ones_d;
    logic [LOG2_LEN-1:0] cyc_q,  cyc_d;

    // Next-count: clear wins over enable; ones can reach N, hence one extra bit
    always_comb begin
        ones_d = ones_q;
        cyc_d  = cyc_q;
        if (clr) begin
            ones_d = '0;
            cyc_d  = '0;
        end else if (en) begin
            ones_d = ones_q + (LOG2_LEN+1)'(bit_in);
            cyc_d  = cyc_q + LOG2_LEN'(1);
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
            cyc_q  <= '0;
        end else begin
            ones_q <= ones_d;
            cyc_q  <= cyc_d;
        end
    end

    assign ones        = ones_q;
    assign last_sample = &cyc_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^LOG2_LEN window,
// rescales by the captured nummax and presents the result via valid/ready.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned LOG2_LEN = 8,
    parameter int unsigned NUM_W    = sc_pkg::NUM_W
) (
    input  logic                clkB,
    input  logic                rst,
    input  logic                start,
    input  logic                bit_in,
    input  logic [NUM_W-1:0]    nummax_in,
    output logic                busy,
    output logic                valid,
    input  logic                ready,
    output logic [LOG2_LEN:0]   count,
    output logic [NUM_W-1:0]    value
);

    localparam int unsigned PROD_W = LOG2_LEN + 1 + NUM_W;

    sc_dec_state_t       state_q, state_d;
    logic [NUM_W-1:0]    nm_q, nm_d;
    logic [LOG2_LEN:0]   count_q, count_d;
    logic [NUM_W-1:0]    value_q, value_d;

    logic                win_clr;
    logic                win_en;
    logic [LOG2_LEN:0]   ones;
    logic                last_sample;
    logic [PROD_W-1:0]   prod;

    sc_window_counter #(
        .LOG2_LEN (LOG2_LEN)
    ) u_window (
        .clk         (clkB),
        .rst         (rst),
        .clr         (win_clr),
        .en          (win_en),
        .bit_in      (bit_in),
        .ones        (ones),
        .last_sample (last_sample)
    );

    // Full-width product; ones <= N guarantees the shifted result fits NUM_W
    always_comb begin
        prod = PROD_W'(ones) * PROD_W'(nm_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        nm_d    = nm_q;
        count_d = count_q;
        value_d = value_q;
        win_clr = 1'b0;
        win_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nm_d    = nummax_in;
                    win_clr = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                win_en = 1'b1;
                if (last_sample) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                count_d = ones;
                value_d = prod[LOG2_LEN +: NUM_W];
                state_d = DONE;
            end
            DONE: begin
                if (ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clkB) begin
        if (rst) begin
            state_q <= IDLE;
            nm_q    <= '0;
            count_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            nm_q    <= nm_d;
            count_q <= count_d;
            value_q <= value_d;
        end
    end

    assign busy  = (state_q == ACCUM) || (state_q == CALC);
    assign valid = (state_q == DONE);
    assign count = count_q;
    assign value = value_q;

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary decoder at the consuming end of the stochastic adder chain. It counts the ones in a stochastic bitstream over a fixed window of 2^LOG2_LEN clock cycles. It then rescales the count by the stream's 9-bit nummax scaling factor and returns the binary result through a valid/ready handshake. It turns the scaled-sum stream and nummax produced by the adder stage back into a number.

## Interface

Parameters:
- LOG2_LEN, default 8: log2 of the observation window length, in cycles (N = 2^LOG2_LEN). Legal range 1..16.
- NUM_W, default 9: width of nummax and of the decoded value.

Ports:
- clkB, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: starts a conversion. Only honoured in IDLE.
- bit_in, input, 1: stochastic bitstream, sampled once per cycle during ACCUM.
- nummax_in, input, NUM_W: scaling factor of the stream. Captured on the accepted start edge.
- busy, output, 1: high in ACCUM and CALC.
- valid, output, 1: result available (DONE state).
- ready, input, 1: consumer accepts the result.
- count, output, LOG2_LEN+1: number of ones seen in the window, range 0..N.
- value, output, NUM_W: decoded value, (count × nummax) >> LOG2_LEN, truncated.

## Operation

States: IDLE, ACCUM, CALC, DONE.
- **IDLE**: busy=0, valid=0.
  - When start=1: capture nummax_in into nm_reg, clear ones counter and cycle counter, go to ACCUM.
- **ACCUM**: each cycle, ones += bit_in and cyc += 1.
  - When the sample being taken is the N-th (cyc == N-1), go to CALC.
- **CALC**: one cycle.
  - Register value = (ones × nm_reg) >> LOG2_LEN. The product is LOG2_LEN+1+NUM_W bits wide, with no overflow.
  - Register count = ones.
  - Go to DONE.
- **DONE**: valid=1.
  - count and value are held stable until ready=1.
  - When ready=1, go to IDLE and deassert valid.

Rules:
- Arithmetic is unsigned. Since ones ≤ N, value ≤ nm_reg, so value always fits in NUM_W bits.
- start outside IDLE is ignored. This includes start in DONE on the same cycle that ready=1; the next conversion needs start in IDLE.
- Changes to nummax_in after capture have no effect on the current conversion.
- ready outside DONE is ignored.
- count and value keep the last result through IDLE and the next ACCUM/CALC, and update only on CALC.

## Timing

- Reset: state=IDLE; busy=0, valid=0, count=0, value=0; internal counters cleared.
  - Reset mid-conversion (ACCUM, CALC or DONE) discards the partial result and takes effect at the next edge.
  - rst has priority over start and ready.
- Let E0 be the rising edge at which start is sampled high in IDLE.
  - bit_in is sampled at edges E1..EN, exactly N samples. The bit present at E0 is not counted.
  - The state is CALC after EN.
  - valid rises after E(N+1). Latency from start to valid is N+1 cycles.
- busy is high from after E0 until after E(N+1).
- Handshake: the transfer happens at the edge where valid=1 and ready=1. valid is low the cycle after the transfer.
  - Minimum start-to-start period is N+3 cycles with ready tied high.

## Structure

- Shared package sc_pkg holds:
  - NUM_W = 9, matching nummax across the stochastic blocks.
  - State enum sc_dec_state_t {IDLE, ACCUM, CALC, DONE}.
- One sub-module is natural: sc_window_counter.
  - Contains the ones counter and cycle counter, with clear and enable inputs.
  - Outputs: ones and last_sample.
- FSM, nm_reg, multiplier and output registers stay in sc_stream_decoder.

## Test plan

All scenarios use LOG2_LEN=8 (N=256).
- bit_in=1 for the whole window, nummax_in=100, ready=1: count=256, value=100; valid rises 257 cycles after the start edge.
- bit_in=0 throughout, nummax_in=511: count=0, value=0.
- bit_in alternating 1,0,… starting with 1 at E1, nummax_in=100: count=128, value=50. Repeat with nummax_in=3: count=128, value=1 (truncation).
- Backpressure: ready low for 10 cycles after valid: valid, count and value are held, no new conversion starts. Pulsing start during this time has no effect.
- start re-pulsed during ACCUM and nummax_in changed to 7 mid-window: ignored, and the result uses the captured nummax.
- rst asserted at sample 100 of ACCUM: all outputs 0, state IDLE. A following conversion with all-ones and nummax=200 gives count=256, value=200.
